fetch_byte_queue: RTL and testbench

//  Instruction-fetch byte queue between the ICache and the Decoder. Requests 64-byte

---
 rtl/fetch_byte_queue.sv | 131 +++++++++++++
 tb/tb_fetch_byte_queue.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_byte_queue.sv
// Instruction-fetch byte queue: streams sequential 64-byte ICache lines into a circular
// byte buffer and presents a registered WIN_BYTES-wide decode window at decode_rip.
module fetch_byte_queue #(
   parameter int BUF_LINES = 2,
   parameter int WIN_BYTES = 15
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     set_rip,
   input  logic [63:0]              new_rip,
   output logic                     icache_enable,
   output logic [63:0]              icache_addr,
   input  logic [511:0]             icache_rdata,
   input  logic                     icache_done,
   output logic [0:8*WIN_BYTES-1]   decode_bytes,
   output logic [63:0]              decode_rip,
   output logic                     decode_valid,
   input  logic                     dc_consume,
   input  logic [7:0]               bytes_decoded
);

   localparam int BUF_BYTES = 64 * BUF_LINES;
   localparam int HW        = $clog2(BUF_BYTES);
   localparam int CW        = $clog2(BUF_BYTES + 1);

   typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

   state_t              state, state_next;
   logic [7:0]          buf_mem  [BUF_BYTES];
   logic [7:0]          buf_next [BUF_BYTES];
   logic [HW-1:0]       fill_off [BUF_BYTES];
   logic [HW-1:0]       head, head_next, tail;
   logic [CW-1:0]       count, count_next;
   logic [CW-1:0]       fill_len, take_len;
   logic [63:0]         fetch_addr;
   logic [5:0]          skip;
   logic                started;
   logic                fill, consume, issue;
   logic [0:8*WIN_BYTES-1] window;

   function automatic logic [7:0] line_byte(input logic [511:0] line, input logic [5:0] idx);
      return line[8*idx +: 8];
   endfunction

   assign icache_enable = (state != IDLE);
   assign fill     = (state == REQ) && icache_done && !set_rip;
   assign consume  = dc_consume && decode_valid && !set_rip;
   assign tail     = head + HW'(count);
   assign fill_len = CW'(64) - CW'(skip);
   assign take_len = (bytes_decoded == 8'd0 || bytes_decoded > 8'(WIN_BYTES)) ?
                     CW'(WIN_BYTES) : CW'(bytes_decoded);

   assign head_next  = set_rip ? '0 : (consume ? head + HW'(take_len) : head);
   assign count_next = set_rip ? '0 :
                       count + (fill ? fill_len : '0) - (consume ? take_len : '0);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (started && count <= CW'(BUF_BYTES - 64)) state_next = REQ;
         REQ:     if (icache_done) state_next = IDLE;
         DISCARD: if (icache_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      // A redirect orphans any outstanding line; its done must still be absorbed.
      if (set_rip) state_next = (state != IDLE && !icache_done) ? DISCARD : IDLE;
   end

   assign issue = (state == IDLE) && (state_next == REQ);

   // Buffer image after this cycle's fill; byte j takes line byte (j - tail) + skip.
   always_comb begin
      for (int j = 0; j < BUF_BYTES; j++) begin
         fill_off[j] = HW'(j) - tail;
         buf_next[j] = (fill && CW'(fill_off[j]) < fill_len) ?
                       line_byte(icache_rdata, 6'(fill_off[j] + HW'(skip))) : buf_mem[j];
      end
   end

   always_comb begin
      window = '0;
      for (int i = 0; i < WIN_BYTES; i++)
         window[8*i +: 8] = buf_next[head_next + HW'(i)];
   end

   // NOTE: the byte store has no reset; bytes beyond count are never presented as valid.
   always_ff @(posedge clk) begin
      buf_mem <= buf_next;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         head         <= '0;
         count        <= '0;
         fetch_addr   <= '0;
         skip         <= '0;
         started      <= 1'b0;
         icache_addr  <= '0;
         decode_rip   <= '0;
         decode_valid <= 1'b0;
         decode_bytes <= '0;
      end else begin
         state        <= state_next;
         head         <= head_next;
         count        <= count_next;
         decode_valid <= (count_next >= CW'(WIN_BYTES));
         decode_bytes <= window;
         if (issue) icache_addr <= fetch_addr;
         if (set_rip) begin
            fetch_addr <= {new_rip[63:6], 6'b0};
            skip       <= new_rip[5:0];
            started    <= 1'b1;
            decode_rip <= new_rip;
         end else begin
            if (fill) begin
               fetch_addr <= fetch_addr + 64'd64;
               skip       <= '0;
            end
            if (consume) decode_rip <= decode_rip + 64'(take_len);
         end
      end
   end

   assert property (@(posedge clk) disable iff (!reset)
      (dc_consume && decode_valid && !set_rip) |->
      (bytes_decoded != 8'd0 && bytes_decoded <= 8'(WIN_BYTES)));

endmodule

// File: tb/tb_fetch_byte_queue.sv
// Directed bench for fetch_byte_queue: an ICache model serves lines from an address-derived
// memory image; monitors score consumed windows and request addresses against the bench's model.
module tb_fetch_byte_queue;

   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic          set_rip;
   logic [63:0]   new_rip;
   logic          icache_enable;
   logic [63:0]   icache_addr;
   logic [511:0]  icache_rdata;
   logic          icache_done;
   logic [0:119]  decode_bytes;
   logic [63:0]   decode_rip;
   logic          decode_valid;
   logic          dc_consume;
   logic [7:0]    bytes_decoded;

   int            tests = 0;
   int            fails = 0;
   logic [63:0]   exp_q [$];
   logic [63:0]   model_rip = '0;
   bit            auto_on = 1'b1;

   fetch_byte_queue dut (
      .clk(clk), .reset(reset), .set_rip(set_rip), .new_rip(new_rip),
      .icache_enable(icache_enable), .icache_addr(icache_addr),
      .icache_rdata(icache_rdata), .icache_done(icache_done),
      .decode_bytes(decode_bytes), .decode_rip(decode_rip), .decode_valid(decode_valid),
      .dc_consume(dc_consume), .bytes_decoded(bytes_decoded)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] mem_byte(input logic [63:0] a);
      return a[7:0] + a[15:8] + a[23:16] - 8'h10;
   endfunction

   function automatic logic [511:0] mem_line(input logic [63:0] a);
      logic [511:0] l;
      for (int k = 0; k < 64; k++) l[8*k +: 8] = mem_byte({a[63:6], 6'b0} + 64'(k));
      return l;
   endfunction

   function automatic logic [0:119] mem_window(input logic [63:0] a);
      logic [0:119] w;
      for (int k = 0; k < 15; k++) w[8*k +: 8] = mem_byte(a + 64'(k));
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect(input logic [63:0] a);
      new_rip = a;
      set_rip = 1'b1;
      tick();
      set_rip   = 1'b0;
      model_rip = a;
   endtask

   task automatic wait_valid();
      int c = 0;
      while (!decode_valid && c < 200) begin tick(); c++; end
      if (!decode_valid) check("valid_timeout", 128'(decode_valid), 128'd1);
   endtask

   task automatic wait_en();
      int c = 0;
      while (!icache_enable && c < 50) begin tick(); c++; end
      if (!icache_enable) check("req_timeout", 128'(icache_enable), 128'd1);
   endtask

   task automatic consume(input int n);
      wait_valid();
      exp_q.push_back(model_rip);
      dc_consume    = 1'b1;
      bytes_decoded = 8'(n);
      tick();
      dc_consume = 1'b0;
      model_rip  = model_rip + 64'(n);
   endtask

   task automatic serve(input logic [511:0] line);
      icache_rdata = line;
      icache_done  = 1'b1;
      tick();
      icache_done  = 1'b0;
   endtask

   // Stop the auto ICache, redirect, and absorb any orphaned request by hand.
   task automatic manual_redirect(input logic [63:0] a);
      auto_on = 1'b0;
      repeat (LAT + 4) tick();
      redirect(a);
      if (icache_enable) serve({64{8'hEE}});
      wait_en();
   endtask

   // ICache model: answers each request LAT cycles after it appears.
   initial begin
      bit ok;
      forever begin
         tick();
         if (auto_on && icache_enable) begin
            ok = 1'b1;
            for (int c = 0; c < LAT; c++) begin
               tick();
               if (!icache_enable) ok = 1'b0;
            end
            if (ok) serve(mem_line(icache_addr));
         end
      end
   end

   // Request monitor: each new request must target the next sequential line.
   initial begin
      logic [63:0] next_addr;
      logic        prev_en;
      next_addr = '0;
      prev_en   = 1'b0;
      forever begin
         @(posedge clk);
         if (set_rip) next_addr = {new_rip[63:6], 6'b0};
         @(negedge clk);
         if (icache_enable && !prev_en) begin
            check("req_addr", 128'(icache_addr), 128'(next_addr));
            next_addr = next_addr + 64'd64;
         end
         prev_en = icache_enable;
      end
   end

   // Window monitor: every accepted consume is scored against the queued rip.
   initial begin
      logic [63:0] r;
      forever begin
         @(negedge clk);
         if (reset && dc_consume && decode_valid && !set_rip) begin
            check("sb_pending", {127'd0, exp_q.size() != 0}, 128'd1);
            if (exp_q.size() != 0) begin
               r = exp_q.pop_front();
               check("win_rip", 128'(decode_rip), 128'(r));
               check("win_bytes", 128'(decode_bytes), 128'(mem_window(r)));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; set_rip = 1'b0; new_rip = '0; icache_rdata = '0; icache_done = 1'b0;
      dc_consume = 1'b0; bytes_decoded = 8'd1;
      repeat (3) tick();
      check("rst_enable", 128'(icache_enable), 128'd0);
      check("rst_addr",   128'(icache_addr),   128'd0);
      check("rst_rip",    128'(decode_rip),    128'd0);
      check("rst_valid",  128'(decode_valid),  128'd0);
      check("rst_bytes",  128'(decode_bytes),  128'd0);
      reset = 1'b1;
      repeat (5) tick();
      check("no_fetch_before_rip", 128'(icache_enable), 128'd0);

      // First line, then fill to capacity with no consumption.
      redirect(64'h1000);
      wait_valid();
      check("t1_rip",   128'(decode_rip),        128'h1000);
      check("t1_byte0", 128'(decode_bytes[0:7]),  128'h00);
      check("t1_byte1", 128'(decode_bytes[8:15]), 128'h01);
      repeat (20) tick();
      check("full_no_req", 128'(icache_enable), 128'd0);

      consume(5); consume(3); consume(7);
      check("t3_rip", 128'(decode_rip), 128'h100F);
      consume(15); consume(15); consume(15);
      check("count68_no_req", 128'(icache_enable), 128'd0);
      consume(4);
      wait_en();
      check("refetch_after_64", 128'(icache_enable), 128'd1);
      for (int i = 0; i < 20; i++) consume(15);

      // Mid-line redirect: leading bytes skipped, following line streamed.
      redirect(64'h1025);
      wait_valid();
      check("t2_rip",   128'(decode_rip),       128'h1025);
      check("t2_byte0", 128'(decode_bytes[0:7]), 128'h25);
      consume(7); consume(15); consume(15); consume(9);

      // Redirect during an outstanding request; done arrives three cycles later.
      manual_redirect(64'h1000);
      check("t4_addr0", 128'(icache_addr), 128'h1000);
      serve(mem_line(64'h1000));
      wait_en();
      check("t4_addr1", 128'(icache_addr), 128'h1040);
      redirect(64'h2000);
      repeat (2) tick();
      check("t4_discard_en",   128'(icache_enable), 128'd1);
      check("t4_discard_addr", 128'(icache_addr),   128'h1040);
      serve({64{8'hEE}});
      check("t4_dropped", 128'(decode_valid), 128'd0);
      auto_on = 1'b1;
      wait_valid();
      check("t4_rip", 128'(decode_rip), 128'h2000);
      consume(15); consume(15);

      // Done coinciding with redirect: the line is dropped.
      manual_redirect(64'h3010);
      check("t5_addr", 128'(icache_addr), 128'h3000);
      new_rip = 64'h4005; set_rip = 1'b1;
      icache_rdata = mem_line(64'h3000); icache_done = 1'b1;
      tick();
      set_rip = 1'b0; icache_done = 1'b0; model_rip = 64'h4005;
      check("t5_empty", 128'(decode_valid), 128'd0);
      check("t5_rip",   128'(decode_rip),   128'h4005);
      auto_on = 1'b1;
      wait_valid();
      check("t5_byte0", 128'(decode_bytes[0:7]), 128'h35);

      // Consume coinciding with redirect is ignored.
      new_rip = 64'h5000; set_rip = 1'b1; dc_consume = 1'b1; bytes_decoded = 8'd5;
      tick();
      set_rip = 1'b0; dc_consume = 1'b0; model_rip = 64'h5000;
      check("t5_consume_ignored", 128'(decode_rip), 128'h5000);
      consume(15); consume(6);

      // Asynchronous reset in the middle of a request.
      manual_redirect(64'h6000);
      serve(mem_line(64'h6000));
      wait_en();
      check("t6_pre_valid", 128'(decode_valid), 128'd1);
      check("t6_pre_rip",   128'(decode_rip),   128'h6000);
      reset = 1'b0;
      #1;
      check("t6_enable", 128'(icache_enable), 128'd0);
      check("t6_addr",   128'(icache_addr),   128'd0);
      check("t6_rip",    128'(decode_rip),    128'd0);
      check("t6_valid",  128'(decode_valid),  128'd0);
      check("t6_bytes",  128'(decode_bytes),  128'd0);
      tick();
      reset = 1'b1;
      repeat (5) tick();
      check("t6_no_fetch", 128'(icache_enable), 128'd0);
      check("sb_drained", 128'(exp_q.size()), 128'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
